// File: rtl/pds_port_agent.sv
// pds_port_agent: per-port requester for the PDS power-grant handshake.
// Each port runs its own Moore FSM. It debounces device detection, requests
// budget from the power manager and holds power while granted. It trips to
// FAULT on a filtered overload, then waits out a retry hold-off.
module pds_port_agent #(
    parameter int numPorts  = 8,
    parameter int DET_CYC   = 4,
    parameter int OVL_CYC   = 3,
    parameter int RETRY_CYC = 16,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [numPorts-1:0]   det_ok,
    input  logic [numPorts-1:0]   ovl,
    input  logic [numPorts-1:0]   dis,
    input  logic [numPorts-1:0]   gnt,
    output logic [numPorts-1:0]   req,
    output logic [numPorts-1:0]   off,
    output logic [numPorts-1:0]   fault,
    output logic [numPorts-1:0]   pwr_en,
    output logic [3*numPorts-1:0] port_st
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DETECT  = 3'd1,
        ST_REQUEST = 3'd2,
        ST_POWERED = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    // Terminal counter values; the counter never runs past these, so it cannot wrap.
    localparam logic [CNT_W-1:0] DET_LAST   = CNT_W'(DET_CYC - 1);
    localparam logic [CNT_W-1:0] OVL_LAST   = CNT_W'(OVL_CYC - 1);
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < numPorts; gi++) begin : g_port
            state_t           state_reg;
            logic [CNT_W-1:0] cnt_reg;

            // Per-port FSM; cnt is cleared on every state change.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (det_ok[gi] && !dis[gi]) begin
                                state_reg <= ST_DETECT;
                                cnt_reg   <= '0;
                            end
                        end
                        ST_DETECT: begin
                            if (dis[gi] || !det_ok[gi]) begin
                                state_reg <= ST_IDLE;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == DET_LAST) begin
                                state_reg <= ST_REQUEST;
                                cnt_reg   <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_ONE;
                            end
                        end
                        ST_REQUEST: begin
                            // No timeout: wait for budget as long as the device stays.
                            if (dis[gi] || !det_ok[gi]) begin
                                state_reg <= ST_IDLE;
                                cnt_reg   <= '0;
                            end else if (gnt[gi]) begin
                                state_reg <= ST_POWERED;
                                cnt_reg   <= '0;
                            end
                        end
                        ST_POWERED: begin
                            // Disable beats a trip; a trip beats detect loss and revoke.
                            if (dis[gi]) begin
                                state_reg <= ST_IDLE;
                                cnt_reg   <= '0;
                            end else if (ovl[gi] && (cnt_reg == OVL_LAST)) begin
                                state_reg <= ST_FAULT;
                                cnt_reg   <= '0;
                            end else if (!det_ok[gi]) begin
                                state_reg <= ST_IDLE;
                                cnt_reg   <= '0;
                            end else if (!gnt[gi]) begin
                                state_reg <= ST_REQUEST;
                                cnt_reg   <= '0;
                            end else if (ovl[gi]) begin
                                cnt_reg <= cnt_reg + CNT_ONE;
                            end else begin
                                cnt_reg <= '0;
                            end
                        end
                        ST_FAULT: begin
                            // Hold-off ignores dis, det_ok and gnt entirely.
                            if (cnt_reg == RETRY_LAST) begin
                                state_reg <= ST_IDLE;
                                cnt_reg   <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_ONE;
                            end
                        end
                        default: begin
                            state_reg <= ST_IDLE;
                            cnt_reg   <= '0;
                        end
                    endcase
                end
            end

            assign req[gi]    = (state_reg == ST_REQUEST) || (state_reg == ST_POWERED);
            assign off[gi]    = (state_reg == ST_IDLE) || (state_reg == ST_DETECT) ||
                                (state_reg == ST_FAULT);
            assign fault[gi]  = (state_reg == ST_FAULT);
            assign pwr_en[gi] = (state_reg == ST_POWERED);
            assign port_st[3*gi +: 3] = state_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pds_port_agent.sv
// Directed bench for pds_port_agent: one task per scenario, inline checks.
module tb_pds_port_agent;

    logic        clk;
    logic        reset_n;
    logic [7:0]  det_ok;
    logic [7:0]  ovl;
    logic [7:0]  dis;
    logic [7:0]  gnt;
    logic [7:0]  req;
    logic [7:0]  off;
    logic [7:0]  fault;
    logic [7:0]  pwr_en;
    logic [23:0] port_st;

    int errors = 0;
    int checks = 0;

    pds_port_agent #(
        .numPorts(8), .DET_CYC(4), .OVL_CYC(3), .RETRY_CYC(16), .CNT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .det_ok(det_ok), .ovl(ovl), .dis(dis),
        .gnt(gnt), .req(req), .off(off), .fault(fault), .pwr_en(pwr_en),
        .port_st(port_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // Advance one edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        det_ok  = '0; ovl = '0; dis = '0; gnt = '0;
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        step();
    endtask

    // Bring port p to POWERED: DETECT after edge 1, REQUEST after edge 5, POWERED after edge 6.
    task automatic bring_up(input int p);
        det_ok[p] = 1'b1;
        gnt[p]    = 1'b1;
        repeat (6) step();
        checks++;
        if (port_st[3*p +: 3] !== 3'd3) begin
            errors++;
            $display("FAIL bring_up port %0d state: got %0d want 3", p, port_st[3*p +: 3]);
        end
        $display("bring_up port %0d st=%0d", p, port_st[3*p +: 3]);
    endtask

    task automatic test_reset();
        det_ok = '0; ovl = '0; dis = '0; gnt = '0;
        reset_n = 1'b0;
        #7;
        checks++;
        if (req !== 8'h00) begin errors++; $display("FAIL reset req: got %h want 00", req); end
        checks++;
        if (off !== 8'hFF) begin errors++; $display("FAIL reset off: got %h want ff", off); end
        checks++;
        if (fault !== 8'h00) begin errors++; $display("FAIL reset fault: got %h want 00", fault); end
        checks++;
        if (pwr_en !== 8'h00) begin errors++; $display("FAIL reset pwr_en: got %h want 00", pwr_en); end
        checks++;
        if (port_st !== 24'h0) begin errors++; $display("FAIL reset port_st: got %h want 000000", port_st); end
        $display("test_reset req=%h off=%h fault=%h pwr_en=%h st=%h", req, off, fault, pwr_en, port_st);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_detect_grant();
        do_reset();
        det_ok[0] = 1'b1;
        step();                       // edge k
        checks++;
        if (port_st[2:0] !== 3'd1) begin errors++; $display("FAIL det0 detect state: got %0d want 1", port_st[2:0]); end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (req[0] !== 1'b0) begin errors++; $display("FAIL det0 early req at k+%0d: got %b want 0", i, req[0]); end
        end
        step();                       // edge k+4
        checks++;
        if (req[0] !== 1'b1 || port_st[2:0] !== 3'd2 || off[0] !== 1'b0) begin
            errors++;
            $display("FAIL det0 request: got req=%b st=%0d off=%b want req=1 st=2 off=0", req[0], port_st[2:0], off[0]);
        end
        step(); step();               // manager answers two cycles later
        gnt[0] = 1'b1;
        step();
        checks++;
        if (pwr_en[0] !== 1'b1 || port_st[2:0] !== 3'd3 || off[0] !== 1'b0 || req[0] !== 1'b1) begin
            errors++;
            $display("FAIL det0 grant: got pwr_en=%b st=%0d off=%b req=%b want 1 3 0 1", pwr_en[0], port_st[2:0], off[0], req[0]);
        end
        $display("test_detect_grant st=%0d pwr_en=%b", port_st[2:0], pwr_en[0]);
    endtask

    task automatic test_detect_glitch();
        do_reset();
        det_ok[1] = 1'b1;
        repeat (3) step();
        det_ok[1] = 1'b0;
        step();
        checks++;
        if (port_st[5:3] !== 3'd0) begin errors++; $display("FAIL glitch idle: got %0d want 0", port_st[5:3]); end
        det_ok[1] = 1'b1;
        repeat (4) step();            // edges m .. m+3
        checks++;
        if (req[1] !== 1'b0) begin errors++; $display("FAIL glitch early req: got %b want 0", req[1]); end
        step();                       // edge m+4
        checks++;
        if (req[1] !== 1'b1) begin errors++; $display("FAIL glitch req: got %b want 1", req[1]); end
        $display("test_detect_glitch st=%0d req=%b", port_st[5:3], req[1]);
    endtask

    task automatic test_overload();
        logic [0:5] pattern;
        int high_cycles;
        do_reset();
        bring_up(2);
        pattern = 6'b110111;
        for (int i = 0; i < 5; i++) begin
            ovl[2] = pattern[i];
            step();
            checks++;
            if (port_st[8:6] !== 3'd3) begin errors++; $display("FAIL ovl filter sample %0d: got st=%0d want 3", i, port_st[8:6]); end
        end
        ovl[2] = pattern[5];
        step();
        checks++;
        if (port_st[8:6] !== 3'd4 || fault[2] !== 1'b1 || pwr_en[2] !== 1'b0 || off[2] !== 1'b1) begin
            errors++;
            $display("FAIL ovl trip: got st=%0d fault=%b pwr_en=%b off=%b want 4 1 0 1", port_st[8:6], fault[2], pwr_en[2], off[2]);
        end
        ovl[2] = 1'b0;
        high_cycles = 1;
        for (int i = 0; i < 40 && fault[2] === 1'b1; i++) begin
            step();
            if (fault[2] === 1'b1) high_cycles++;
        end
        checks++;
        if (high_cycles !== 16) begin errors++; $display("FAIL fault hold length: got %0d want 16", high_cycles); end
        checks++;
        if (port_st[8:6] !== 3'd0 || off[2] !== 1'b1) begin
            errors++;
            $display("FAIL after hold: got st=%0d off=%b want 0 1", port_st[8:6], off[2]);
        end
        $display("test_overload hold=%0d st=%0d", high_cycles, port_st[8:6]);
    endtask

    task automatic test_revoke();
        do_reset();
        bring_up(4);
        gnt[4] = 1'b0;
        step();
        checks++;
        if (port_st[14:12] !== 3'd2 || pwr_en[4] !== 1'b0 || req[4] !== 1'b1) begin
            errors++;
            $display("FAIL revoke: got st=%0d pwr_en=%b req=%b want 2 0 1", port_st[14:12], pwr_en[4], req[4]);
        end
        gnt[4] = 1'b1;
        step();
        checks++;
        if (port_st[14:12] !== 3'd3 || pwr_en[4] !== 1'b1) begin
            errors++;
            $display("FAIL regrant: got st=%0d pwr_en=%b want 3 1", port_st[14:12], pwr_en[4]);
        end
        $display("test_revoke st=%0d pwr_en=%b", port_st[14:12], pwr_en[4]);
    endtask

    task automatic test_simultaneous();
        do_reset();
        bring_up(3);
        bring_up(5);
        // Port 3: dis with the trip edge; port 5: det_ok loss with the trip edge.
        ovl[3] = 1'b1; ovl[5] = 1'b1;
        step(); step();
        dis[3] = 1'b1; det_ok[5] = 1'b0;
        step();
        checks++;
        if (port_st[11:9] !== 3'd0 || fault[3] !== 1'b0) begin
            errors++;
            $display("FAIL dis+trip: got st=%0d fault=%b want 0 0", port_st[11:9], fault[3]);
        end
        checks++;
        if (port_st[17:15] !== 3'd4 || fault[5] !== 1'b1) begin
            errors++;
            $display("FAIL detloss+trip: got st=%0d fault=%b want 4 1", port_st[17:15], fault[5]);
        end
        step();
        checks++;
        if (fault[3] !== 1'b0) begin errors++; $display("FAIL dis+trip later fault: got %b want 0", fault[3]); end
        // Port 6: grant arriving together with dis in REQUEST.
        det_ok[6] = 1'b1;
        repeat (5) step();
        checks++;
        if (port_st[20:18] !== 3'd2) begin errors++; $display("FAIL port6 request: got %0d want 2", port_st[20:18]); end
        gnt[6] = 1'b1; dis[6] = 1'b1;
        step();
        checks++;
        if (port_st[20:18] !== 3'd0 || pwr_en[6] !== 1'b0) begin
            errors++;
            $display("FAIL gnt+dis: got st=%0d pwr_en=%b want 0 0", port_st[20:18], pwr_en[6]);
        end
        $display("test_simultaneous st3=%0d st5=%0d st6=%0d", port_st[11:9], port_st[17:15], port_st[20:18]);
    endtask

    task automatic test_async_reset();
        do_reset();
        bring_up(7);
        ovl[7] = 1'b1;
        repeat (3) step();            // trip edge: fault cycle 1
        ovl[7] = 1'b0;
        repeat (4) step();            // fault cycle 5
        checks++;
        if (fault[7] !== 1'b1) begin errors++; $display("FAIL pre-reset fault: got %b want 1", fault[7]); end
        #2;
        reset_n = 1'b0;
        #1;                           // still well before the next edge
        checks++;
        if (fault !== 8'h00 || port_st !== 24'h0 || off !== 8'hFF || pwr_en !== 8'h00 || req !== 8'h00) begin
            errors++;
            $display("FAIL async reset: got fault=%h st=%h off=%h pwr_en=%h req=%h want 00 000000 ff 00 00",
                     fault, port_st, off, pwr_en, req);
        end
        $display("test_async_reset fault=%h st=%h", fault, port_st);
        #3;
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_detect_grant();
        test_detect_glitch();
        test_overload();
        test_revoke();
        test_simultaneous();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
